mem_arb_2to1: RTL and testbench
===============================

MEM_ARB_2TO1 -- requirements
Module: mem_arb_2to1

Interface
REQ-001 The block SHALL have parameter MAX_OUTST, default 4, meaning the maximum number of in-flight (granted, unanswered) requests; legal values are powers of two, 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-004 The block SHALL have ports in0_req_msg, input, mem_req_16B_t; in0_req_val, input, 1; in0_req_rdy, output, 1: the port-0 (instruction) request channel from proc_with_cache.
REQ-005 The block SHALL have ports in0_resp_msg, output, mem_resp_16B_t; in0_resp_val, output, 1; in0_resp_rdy, input, 1: the port-0 response channel.
REQ-006 The block SHALL have ports in1_req_* and in1_resp_*, with the same types and directions as port 0: the data-side channels.
REQ-007 The block SHALL have ports out_req_msg, output, mem_req_16B_t; out_req_val, output, 1; out_req_rdy, input, 1: the request channel to ram_x128_wrap.
REQ-008 The block SHALL have ports out_resp_msg, input, mem_resp_16B_t; out_resp_val, input, 1; out_resp_rdy, output, 1: the response channel from ram_x128_wrap.

Function
REQ-009 A transfer on any channel SHALL occur only in a cycle where val and rdy are both high; val SHALL NOT depend combinationally on rdy of the same channel.
REQ-010 The arbiter SHALL be round-robin with a 1-bit priority pointer prio; with both inputs valid, grant SHALL go to port prio, otherwise to the single valid port.
REQ-011 prio SHALL update only on an out_req transfer, to the opposite of the granted port.
REQ-012 Requests SHALL pass combinationally with zero added latency: out_req_msg is the granted input's msg, and out_req_val = (in0_req_val | in1_req_val) & !full.
REQ-013 inN_req_rdy SHALL equal (grant==N) & out_req_rdy & !full; the non-granted port SHALL see rdy=0.
REQ-014 Message contents SHALL be forwarded bit-exact, unmodified, in both directions.
REQ-015 An order FIFO of depth MAX_OUTST holding 1-bit port IDs SHALL push the granted ID on each out_req transfer and pop on each out_resp transfer.
REQ-016 A counter cnt (width clog2(MAX_OUTST)+1) SHALL track FIFO occupancy; full = (cnt==MAX_OUTST), empty = (cnt==0).
REQ-017 When full, no new request SHALL be accepted, even if a response pops in the same cycle; acceptance resumes the following cycle.
REQ-018 A push and a pop in the same cycle SHALL leave cnt unchanged and update both read and write pointers; pointers SHALL wrap modulo MAX_OUTST.
REQ-019 Response routing: with head ID h, in<h>_resp_val = out_resp_val & !empty, in<h>_resp_msg = out_resp_msg, and out_resp_rdy = in<h>_resp_rdy & !empty; the other port's resp_val SHALL be 0.
REQ-020 When empty, out_resp_rdy SHALL be 0, so a spurious response is stalled, not dropped.
REQ-021 Responses SHALL be returned in grant order; the block relies on in-order memory responses.
REQ-022 Stall on one port's response SHALL block all responses (head-of-line), with no reordering.
REQ-023 Inputs whose msg changes while val is high and unaccepted SHALL NOT corrupt state; the msg is sampled only at transfer.

Reset
REQ-024 While rst_n=0, asynchronously: cnt=0, FIFO pointers=0, prio=0; all *_val and *_rdy outputs SHALL read 0.
REQ-025 Deassertion of rst_n SHALL be honoured on the next rising clk edge; any in-flight requests are discarded without responses.

Verification
REQ-026 Both ports send continuously, memory is always ready -> grants alternate 0,1,0,1 starting with port 0; each response returns to the correct port in order.
REQ-027 Only port 1 sends 3 requests -> all three are granted back-to-back, and prio=0 after each.
REQ-028 out_resp_rdy is held at 0 by memory stall with MAX_OUTST=4, and 4 requests are accepted -> fifth request sees in*_req_rdy=0 until the first response transfers, then is accepted the next cycle.
REQ-029 Full FIFO with a response pop and a pending request in the same cycle -> the request is not accepted that cycle, cnt goes 4->3, and the request is accepted the next cycle with cnt 3->4.
REQ-030 Port 0 response stalled (in0_resp_rdy=0) with port-1 response next -> out_resp_rdy=0 and in1_resp_val=0 until port 0 accepts.
REQ-031 rst_n pulsed low mid-operation with cnt=2 -> outputs drop to 0 immediately; after release, cnt=0 and the first grant goes to port 0.

Source files
------------

// File: rtl/mem_msg_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : mem_msg_pkg                                            |
// | Brief   : 16-byte memory request/response message formats shared |
// |           by the cache, the port arbiter and the RAM wrapper.    |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package mem_msg_pkg;

  typedef struct packed {
    logic [2:0]   typ;
    logic [7:0]   opaque;
    logic [31:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_req_16B_t;

  typedef struct packed {
    logic [2:0]   typ;
    logic [7:0]   opaque;
    logic [1:0]   test;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_resp_16B_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_2to1.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : mem_arb_2to1                                            |
// | Brief  : Round-robin 2:1 memory request arbiter with an in-order |
// |          port-ID FIFO that steers responses back to their owner. |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module mem_arb_2to1 #(
  parameter int MAX_OUTST = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,

  input  mem_msg_pkg::mem_req_16B_t  in0_req_msg,
  input  logic                       in0_req_val,
  output logic                       in0_req_rdy,
  output mem_msg_pkg::mem_resp_16B_t in0_resp_msg,
  output logic                       in0_resp_val,
  input  logic                       in0_resp_rdy,

  input  mem_msg_pkg::mem_req_16B_t  in1_req_msg,
  input  logic                       in1_req_val,
  output logic                       in1_req_rdy,
  output mem_msg_pkg::mem_resp_16B_t in1_resp_msg,
  output logic                       in1_resp_val,
  input  logic                       in1_resp_rdy,

  output mem_msg_pkg::mem_req_16B_t  out_req_msg,
  output logic                       out_req_val,
  input  logic                       out_req_rdy,
  input  mem_msg_pkg::mem_resp_16B_t out_resp_msg,
  input  logic                       out_resp_val,
  output logic                       out_resp_rdy
);

  localparam int                 C_PTR_W = $clog2(MAX_OUTST);
  localparam int                 C_CNT_W = C_PTR_W + 1;
  localparam logic [C_CNT_W-1:0] C_FULL  = C_CNT_W'(MAX_OUTST);

  logic [C_CNT_W-1:0]   r_cnt;
  logic [C_PTR_W-1:0]   r_wr_ptr;
  logic [C_PTR_W-1:0]   r_rd_ptr;
  logic [MAX_OUTST-1:0] r_ids;
  logic                 r_prio;

  logic w_full;
  logic w_empty;
  logic w_grant;
  logic w_push;
  logic w_pop;
  logic w_head;

  assign w_full  = (r_cnt == C_FULL);
  assign w_empty = (r_cnt == '0);

  // Grant selection: the priority pointer breaks ties, otherwise the lone requester wins
  always_comb begin
    w_grant = 1'b0;
    if (in0_req_val && in1_req_val) begin
      w_grant = r_prio;
    end else begin
      w_grant = in1_req_val;
    end
  end

  // Request path is purely combinational; rst_n gating keeps handshakes quiet during reset
  assign out_req_msg = w_grant ? in1_req_msg : in0_req_msg;
  assign out_req_val = rst_n & (in0_req_val | in1_req_val) & ~w_full;
  assign in0_req_rdy = rst_n & ~w_grant & out_req_rdy & ~w_full;
  assign in1_req_rdy = rst_n &  w_grant & out_req_rdy & ~w_full;
  assign w_push      = out_req_val & out_req_rdy;

  // Responses follow the FIFO head; nothing is accepted from memory while empty
  assign w_head       = r_ids[r_rd_ptr];
  assign in0_resp_msg = out_resp_msg;
  assign in1_resp_msg = out_resp_msg;
  assign in0_resp_val = out_resp_val & ~w_empty & ~w_head;
  assign in1_resp_val = out_resp_val & ~w_empty &  w_head;
  assign out_resp_rdy = ~w_empty & (w_head ? in1_resp_rdy : in0_resp_rdy);
  assign w_pop        = out_resp_val & out_resp_rdy;

  // Round-robin pointer moves to the other port after every forwarded request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (w_push) begin
      r_prio <= ~w_grant;
    end
  end

  // Order FIFO: record the granted port on push, advance the head on pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ids    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_ids[r_wr_ptr] <= w_grant;
        r_wr_ptr        <= r_wr_ptr + C_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
      end
    end
  end

  // Occupancy counter; simultaneous push and pop cancel out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + C_CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - C_CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arb_2to1.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_mem_arb_2to1                                         |
// | Brief  : Directed self-checking bench for mem_arb_2to1.          |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module tb_mem_arb_2to1;
  import mem_msg_pkg::*;

  logic          clk;
  logic          rst_n;
  mem_req_16B_t  in0_req_msg, in1_req_msg, out_req_msg;
  logic          in0_req_val, in0_req_rdy, in1_req_val, in1_req_rdy;
  mem_resp_16B_t in0_resp_msg, in1_resp_msg, out_resp_msg;
  logic          in0_resp_val, in0_resp_rdy, in1_resp_val, in1_resp_rdy;
  logic          out_req_val, out_req_rdy, out_resp_val, out_resp_rdy;

  int checks = 0;
  int errors = 0;

  mem_arb_2to1 #(.MAX_OUTST(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in0_req_msg  (in0_req_msg),
    .in0_req_val  (in0_req_val),
    .in0_req_rdy  (in0_req_rdy),
    .in0_resp_msg (in0_resp_msg),
    .in0_resp_val (in0_resp_val),
    .in0_resp_rdy (in0_resp_rdy),
    .in1_req_msg  (in1_req_msg),
    .in1_req_val  (in1_req_val),
    .in1_req_rdy  (in1_req_rdy),
    .in1_resp_msg (in1_resp_msg),
    .in1_resp_val (in1_resp_val),
    .in1_resp_rdy (in1_resp_rdy),
    .out_req_msg  (out_req_msg),
    .out_req_val  (out_req_val),
    .out_req_rdy  (out_req_rdy),
    .out_resp_msg (out_resp_msg),
    .out_resp_val (out_resp_val),
    .out_resp_rdy (out_resp_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mem_req_16B_t mk_req(input logic [7:0] t);
    mem_req_16B_t r;
    r.typ    = t[2:0];
    r.opaque = t;
    r.addr   = {4{t}};
    r.len    = t[3:0];
    r.data   = {16{t}};
    return r;
  endfunction

  function automatic mem_resp_16B_t mk_resp(input logic [7:0] t);
    mem_resp_16B_t r;
    r.typ    = t[2:0];
    r.opaque = t;
    r.test   = t[1:0];
    r.len    = t[3:0];
    r.data   = {16{~t}};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, 192'(obs), 192'(exp));
  endtask

  task automatic chk_cnt(input string tag, input logic [2:0] exp);
    chk(tag, 192'(dut.r_cnt), 192'(exp));
  endtask

  initial begin
    rst_n        = 1'b0;
    in0_req_msg  = mk_req(8'h00);
    in1_req_msg  = mk_req(8'h00);
    out_resp_msg = mk_resp(8'h00);
    in0_req_val  = 1'b0;
    in1_req_val  = 1'b0;
    in0_resp_rdy = 1'b1;
    in1_resp_rdy = 1'b1;
    out_req_rdy  = 1'b1;
    out_resp_val = 1'b0;

    // Reset held with traffic present: all handshakes must be low
    @(negedge clk);
    in0_req_val = 1'b1; in1_req_val = 1'b1; out_resp_val = 1'b1;
    #1;
    chk1("rst_out_req_val", out_req_val, 1'b0);
    chk1("rst_in0_req_rdy", in0_req_rdy, 1'b0);
    chk1("rst_in1_req_rdy", in1_req_rdy, 1'b0);
    chk1("rst_out_resp_rdy", out_resp_rdy, 1'b0);
    chk1("rst_in0_resp_val", in0_resp_val, 1'b0);
    chk1("rst_in1_resp_val", in1_resp_val, 1'b0);
    chk_cnt("rst_cnt", 3'd0);
    in0_req_val = 1'b0; in1_req_val = 1'b0; out_resp_val = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // C1..C4: both ports busy, grants alternate 0,1,0,1
    @(negedge clk);
    in0_req_val = 1'b1; in0_req_msg = mk_req(8'h01);
    in1_req_val = 1'b1; in1_req_msg = mk_req(8'h11);
    #1;
    chk1("c1_out_req_val", out_req_val, 1'b1);
    chk("c1_out_req_msg", 192'(out_req_msg), 192'(mk_req(8'h01)));
    chk1("c1_in0_req_rdy", in0_req_rdy, 1'b1);
    chk1("c1_in1_req_rdy", in1_req_rdy, 1'b0);

    @(negedge clk);
    in0_req_msg = mk_req(8'h02);
    #1;
    chk("c2_out_req_msg", 192'(out_req_msg), 192'(mk_req(8'h11)));
    chk1("c2_in1_req_rdy", in1_req_rdy, 1'b1);
    chk1("c2_in0_req_rdy", in0_req_rdy, 1'b0);

    @(negedge clk);
    in1_req_msg = mk_req(8'h12);
    #1;
    chk("c3_out_req_msg", 192'(out_req_msg), 192'(mk_req(8'h02)));
    chk1("c3_in0_req_rdy", in0_req_rdy, 1'b1);

    @(negedge clk);
    in0_req_msg = mk_req(8'h03);
    #1;
    chk("c4_out_req_msg", 192'(out_req_msg), 192'(mk_req(8'h12)));
    chk1("c4_in1_req_rdy", in1_req_rdy, 1'b1);

    // C5: FIFO full, both requesters stalled
    @(negedge clk);
    in1_req_msg = mk_req(8'h13);
    #1;
    chk_cnt("c5_cnt_full", 3'd4);
    chk1("c5_out_req_val", out_req_val, 1'b0);
    chk1("c5_in0_req_rdy", in0_req_rdy, 1'b0);
    chk1("c5_in1_req_rdy", in1_req_rdy, 1'b0);
    chk1("c5_in0_resp_val", in0_resp_val, 1'b0);

    // C6: response pops while full; pending request (msg changed while waiting) still refused
    @(negedge clk);
    in0_req_msg = mk_req(8'h04); in1_req_msg = mk_req(8'h14);
    out_resp_val = 1'b1; out_resp_msg = mk_resp(8'hA0);
    #1;
    chk1("c6_out_req_val", out_req_val, 1'b0);
    chk1("c6_in0_req_rdy", in0_req_rdy, 1'b0);
    chk1("c6_in0_resp_val", in0_resp_val, 1'b1);
    chk1("c6_in1_resp_val", in1_resp_val, 1'b0);
    chk("c6_in0_resp_msg", 192'(in0_resp_msg), 192'(mk_resp(8'hA0)));
    chk1("c6_out_resp_rdy", out_resp_rdy, 1'b1);
    chk_cnt("c6_cnt", 3'd4);

    // C7: acceptance resumes, port 0 wins with its latest msg
    @(negedge clk);
    out_resp_val = 1'b0;
    #1;
    chk_cnt("c7_cnt", 3'd3);
    chk1("c7_out_req_val", out_req_val, 1'b1);
    chk("c7_out_req_msg", 192'(out_req_msg), 192'(mk_req(8'h04)));
    chk1("c7_in0_req_rdy", in0_req_rdy, 1'b1);

    // C8: head is port 1
    @(negedge clk);
    in0_req_val = 1'b0; in1_req_val = 1'b0;
    out_resp_val = 1'b1; out_resp_msg = mk_resp(8'hA1);
    #1;
    chk_cnt("c8_cnt", 3'd4);
    chk1("c8_prio", dut.r_prio, 1'b1);
    chk1("c8_in1_resp_val", in1_resp_val, 1'b1);
    chk1("c8_in0_resp_val", in0_resp_val, 1'b0);
    chk("c8_in1_resp_msg", 192'(in1_resp_msg), 192'(mk_resp(8'hA1)));
    chk1("c8_out_req_val", out_req_val, 1'b0);

    // C9-C10: head-of-line stall on port 0 blocks the port-1 response behind it
    @(negedge clk);
    out_resp_msg = mk_resp(8'hA2); in0_resp_rdy = 1'b0;
    #1;
    chk_cnt("c9_cnt", 3'd3);
    chk1("c9_in0_resp_val", in0_resp_val, 1'b1);
    chk1("c9_out_resp_rdy", out_resp_rdy, 1'b0);
    chk1("c9_in1_resp_val", in1_resp_val, 1'b0);

    @(negedge clk);
    #1;
    chk_cnt("c10_cnt_held", 3'd3);
    chk1("c10_out_resp_rdy", out_resp_rdy, 1'b0);
    in0_resp_rdy = 1'b1;
    #1;
    chk1("c10_out_resp_rdy_rel", out_resp_rdy, 1'b1);
    chk("c10_in0_resp_msg", 192'(in0_resp_msg), 192'(mk_resp(8'hA2)));

    @(negedge clk);
    out_resp_msg = mk_resp(8'hA3);
    #1;
    chk_cnt("c11_cnt", 3'd2);
    chk1("c11_in1_resp_val", in1_resp_val, 1'b1);
    chk1("c11_in0_resp_val", in0_resp_val, 1'b0);
    chk("c11_in1_resp_msg", 192'(in1_resp_msg), 192'(mk_resp(8'hA3)));

    // C12-C14: only port 1 requests, granted back to back
    @(negedge clk);
    out_resp_val = 1'b0;
    in1_req_val = 1'b1; in1_req_msg = mk_req(8'h21);
    #1;
    chk_cnt("c12_cnt", 3'd1);
    chk1("c12_in1_req_rdy", in1_req_rdy, 1'b1);
    chk("c12_out_req_msg", 192'(out_req_msg), 192'(mk_req(8'h21)));

    @(negedge clk);
    in1_req_msg = mk_req(8'h22);
    #1;
    chk1("c13_prio", dut.r_prio, 1'b0);
    chk_cnt("c13_cnt", 3'd2);
    chk1("c13_in1_req_rdy", in1_req_rdy, 1'b1);
    chk("c13_out_req_msg", 192'(out_req_msg), 192'(mk_req(8'h22)));

    @(negedge clk);
    in1_req_msg = mk_req(8'h23);
    #1;
    chk1("c14_prio", dut.r_prio, 1'b0);
    chk_cnt("c14_cnt", 3'd3);
    chk1("c14_in1_req_rdy", in1_req_rdy, 1'b1);

    // C15-C16: drain two responses, order 0 then 1
    @(negedge clk);
    in1_req_val = 1'b0;
    out_resp_val = 1'b1; out_resp_msg = mk_resp(8'hB0);
    #1;
    chk1("c15_prio", dut.r_prio, 1'b0);
    chk_cnt("c15_cnt", 3'd4);
    chk1("c15_in0_resp_val", in0_resp_val, 1'b1);
    chk("c15_in0_resp_msg", 192'(in0_resp_msg), 192'(mk_resp(8'hB0)));

    @(negedge clk);
    out_resp_msg = mk_resp(8'hB1);
    #1;
    chk_cnt("c16_cnt", 3'd3);
    chk1("c16_in1_resp_val", in1_resp_val, 1'b1);

    // C17: reset pulse mid-operation with two requests outstanding
    @(negedge clk);
    out_resp_val = 1'b0;
    #1;
    chk_cnt("c17_cnt_pre", 3'd2);
    in0_req_val = 1'b1; in0_req_msg = mk_req(8'h31);
    in1_req_val = 1'b1; in1_req_msg = mk_req(8'h41);
    out_resp_val = 1'b1; out_resp_msg = mk_resp(8'hB2);
    rst_n = 1'b0;
    #1;
    chk1("c17_out_req_val", out_req_val, 1'b0);
    chk1("c17_in0_req_rdy", in0_req_rdy, 1'b0);
    chk1("c17_in1_req_rdy", in1_req_rdy, 1'b0);
    chk1("c17_in0_resp_val", in0_resp_val, 1'b0);
    chk1("c17_in1_resp_val", in1_resp_val, 1'b0);
    chk1("c17_out_resp_rdy", out_resp_rdy, 1'b0);
    chk_cnt("c17_cnt", 3'd0);
    chk1("c17_prio", dut.r_prio, 1'b0);

    // C18: released; first grant to port 0, stray response stalled while empty
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk1("c18_out_req_val", out_req_val, 1'b1);
    chk("c18_out_req_msg", 192'(out_req_msg), 192'(mk_req(8'h31)));
    chk1("c18_in0_req_rdy", in0_req_rdy, 1'b1);
    chk1("c18_in1_req_rdy", in1_req_rdy, 1'b0);
    chk1("c18_out_resp_rdy", out_resp_rdy, 1'b0);
    chk1("c18_in0_resp_val", in0_resp_val, 1'b0);
    chk1("c18_in1_resp_val", in1_resp_val, 1'b0);
    chk_cnt("c18_cnt", 3'd0);

    @(negedge clk);
    in0_req_val = 1'b0; in1_req_val = 1'b0; out_resp_val = 1'b0;
    #1;
    chk_cnt("c19_cnt", 3'd1);
    chk1("c19_prio", dut.r_prio, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
